// File: rtl/rst_sequencer.sv
// Board reset controller: synchronises rst_in, releases reset domains in
// order with programmable gaps, and arbitrates soft-reset requests.
module rst_sequencer #(
  parameter int N_DOM     = 3,
  parameter int N_REQ     = 2,
  parameter int PWRUP_DLY = 1000,
  parameter int STAGE_DLY = 16,
  parameter int SOFT_HOLD = 8
) (
  input  logic             clk_50m,
  input  logic             rst_in,
  input  logic [N_REQ-1:0] soft_req,
  output logic [N_REQ-1:0] soft_grant,
  output logic [N_DOM-1:0] rst_n_out,
  output logic             ready,
  output logic             busy
);

  localparam int MAX_AB = (PWRUP_DLY > STAGE_DLY) ? PWRUP_DLY : STAGE_DLY;
  localparam int MAXD   = (MAX_AB > SOFT_HOLD) ? MAX_AB : SOFT_HOLD;
  localparam int CW     = $clog2(MAXD + 1);
  localparam int IW     = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  localparam logic [CW-1:0]    PW_T     = CW'(PWRUP_DLY - 1);
  localparam logic [CW-1:0]    SD_T     = CW'(STAGE_DLY - 1);
  localparam logic [CW-1:0]    SH_T     = CW'(SOFT_HOLD - 1);
  localparam logic [CW-1:0]    CNT_MAX  = {CW{1'b1}};
  localparam logic [IW-1:0]    IDX_LAST = IW'(N_DOM - 1);
  localparam logic [N_DOM-1:0] DOM_ONE  = N_DOM'(1);

  localparam logic [1:0] ST_PWRUP   = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  logic             sync1_q;
  logic             sync2_q;
  logic             rst_sync_n;
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_DOM-1:0] rst_n_q, rst_n_d;
  logic             ready_q, ready_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             rel0;

  // Two-flop synchroniser: async assert, release on the 2nd clean edge
  always_ff @(posedge clk_50m or negedge rst_in) begin
    if (!rst_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= 1'b1;
      sync2_q <= sync1_q;
    end
  end

  assign rst_sync_n = sync2_q;

  // Next-state: power-up wait, staged release, run/arbitrate, soft hold
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    ready_d = ready_q;
    grant_d = '0;
    rel0    = 1'b0;
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    unique case (state_q)
      ST_PWRUP: rel0 = (cnt_q == PW_T);
      ST_HOLD:  rel0 = (cnt_q == SH_T);
      ST_RELEASE: begin
        if (cnt_q == SD_T) begin
          rst_n_d = rst_n_q | (DOM_ONE << idx_q);
          idx_d   = idx_q + 1'b1;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (|soft_req) begin
          grant_d = soft_req & (~soft_req + 1'b1);
          rst_n_d = '0;
          ready_d = 1'b0;
          idx_d   = '0;
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_PWRUP;
    endcase
    if (rel0) begin
      rst_n_d = DOM_ONE;
      idx_d   = IW'(1);
      cnt_d   = '0;
      if (N_DOM == 1) begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end else begin
        state_d = ST_RELEASE;
      end
    end
  end

  // Sequencer state; reset lands in the power-up wait, outputs gated by sync
  always_ff @(posedge clk_50m or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q <= ST_PWRUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      ready_q <= ready_d;
      grant_q <= grant_d;
    end
  end

  assign rst_n_out  = rst_n_q;
  assign ready      = ready_q;
  assign soft_grant = grant_q;
  assign busy       = rst_sync_n & (state_q != ST_RUN);

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed sequences, a grant table and
// random requests/resets checked against a time-based reference model.
module tb_rst_sequencer;

  localparam int ND = 3;
  localparam int NR = 2;
  localparam int PW = 1000;
  localparam int SD = 16;
  localparam int SH = 8;

  logic          clk_50m = 1'b0;
  logic          rst_in  = 1'b1;
  logic [NR-1:0] soft_req = '0;
  logic [NR-1:0] soft_grant;
  logic [ND-1:0] rst_n_out;
  logic          ready;
  logic          busy;

  int errs   = 0;
  int checks = 0;
  int e      = 0;

  int            hi_cnt  = 0;
  bit            act     = 1'b0;
  int            base    = 0;
  bit            m_ready = 1'b0;
  logic [NR-1:0] m_grant = '0;
  logic [ND-1:0] m_rst   = '0;

  typedef struct {
    logic [NR-1:0] req;
    logic [NR-1:0] gnt;
  } vec_t;

  vec_t tbl [3];

  always #10 clk_50m = ~clk_50m;

  rst_sequencer #(
    .N_DOM(ND), .N_REQ(NR), .PWRUP_DLY(PW),
    .STAGE_DLY(SD), .SOFT_HOLD(SH)
  ) dut (
    .clk_50m(clk_50m),
    .rst_in(rst_in),
    .soft_req(soft_req),
    .soft_grant(soft_grant),
    .rst_n_out(rst_n_out),
    .ready(ready),
    .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", nm, e, got, want);
    end
  endtask

  task automatic model_rst();
    act     = 1'b0;
    hi_cnt  = 0;
    m_ready = 1'b0;
    m_grant = '0;
    m_rst   = '0;
  endtask

  // Expected outputs from event times: domain k is out of reset once
  // the edge count reaches base + k*SD.
  task automatic model_edge();
    logic [NR-1:0] g;
    e++;
    g = '0;
    if (!rst_in) begin
      model_rst();
    end else begin
      if (hi_cnt < 2) begin
        hi_cnt++;
        if (hi_cnt == 2) begin
          act  = 1'b1;
          base = e + PW;
        end
      end else if (m_ready && soft_req != '0) begin
        for (int i = NR - 1; i >= 0; i--)
          if (soft_req[i]) begin
            g    = '0;
            g[i] = 1'b1;
          end
        base = e + SH;
      end
      m_grant = g;
      if (act) begin
        for (int k = 0; k < ND; k++)
          m_rst[k] = (e >= base + k * SD);
        m_ready = &m_rst;
      end
    end
  endtask

  task automatic cmp_all();
    chk("rst_n_out", 32'(rst_n_out), 32'(m_rst));
    chk("ready", 32'(ready), 32'(m_ready));
    chk("busy", 32'(busy), 32'(act && !m_ready));
    chk("soft_grant", 32'(soft_grant), 32'(m_grant));
  endtask

  task automatic step();
    @(posedge clk_50m);
    model_edge();
    #1;
    cmp_all();
  endtask

  task automatic run_to(input int t);
    while (e < t) step();
  endtask

  task automatic set_rst(input logic v);
    rst_in = v;
    if (!v) model_rst();
    #1;
    cmp_all();
  endtask

  task automatic por(output int e2);
    set_rst(1'b0);
    repeat (10) step();
    #4;
    set_rst(1'b1);
    step();
    step();
    e2 = e;
  endtask

  int e2;
  int g0;
  int g1;

  initial begin
    tbl[0] = '{req: 2'b01, gnt: 2'b01};
    tbl[1] = '{req: 2'b10, gnt: 2'b10};
    tbl[2] = '{req: 2'b11, gnt: 2'b01};

    #5;
    // power-on sequence
    por(e2);
    chk("t1 busy@E2", 32'(busy), 32'd1);
    chk("t1 rst@E2", 32'(rst_n_out), 32'd0);
    run_to(e2 + PW - 1);
    chk("t1 pre", 32'(rst_n_out), 32'd0);
    step();
    chk("t1 d0", 32'(rst_n_out), 32'b001);
    run_to(e2 + PW + SD - 1);
    chk("t1 d0 hold", 32'(rst_n_out), 32'b001);
    step();
    chk("t1 d1", 32'(rst_n_out), 32'b011);
    run_to(e2 + PW + 2 * SD - 1);
    chk("t1 ready pre", 32'(ready), 32'd0);
    chk("t1 busy pre", 32'(busy), 32'd1);
    step();
    chk("t1 d2", 32'(rst_n_out), 32'b111);
    chk("t1 ready", 32'(ready), 32'd1);
    chk("t1 busy", 32'(busy), 32'd0);

    // soft-reset grant table
    for (int i = 0; i < 3; i++) begin
      soft_req = tbl[i].req;
      step();
      g0 = e;
      chk("tbl grant", 32'(soft_grant), 32'(tbl[i].gnt));
      chk("tbl rst0", 32'(rst_n_out), 32'd0);
      chk("tbl busy", 32'(busy), 32'd1);
      soft_req = '0;
      step();
      chk("tbl pulse", 32'(soft_grant), 32'd0);
      run_to(g0 + SH - 1);
      chk("tbl hold", 32'(rst_n_out), 32'd0);
      step();
      chk("tbl d0", 32'(rst_n_out), 32'b001);
      run_to(g0 + SH + SD);
      chk("tbl d1", 32'(rst_n_out), 32'b011);
      run_to(g0 + SH + 2 * SD - 1);
      chk("tbl ready pre", 32'(ready), 32'd0);
      step();
      chk("tbl d2", 32'(rst_n_out), 32'b111);
      chk("tbl ready", 32'(ready), 32'd1);
    end

    // loser keeps requesting, re-granted on first RUN edge
    soft_req = 2'b11;
    step();
    g0 = e;
    chk("arb first", 32'(soft_grant), 32'b01);
    soft_req = 2'b10;
    run_to(g0 + SH + 2 * SD);
    chk("arb ready", 32'(ready), 32'd1);
    chk("arb no early", 32'(soft_grant), 32'd0);
    step();
    g1 = e;
    chk("arb second", 32'(soft_grant), 32'b10);
    soft_req = '0;
    run_to(g1 + SH + 2 * SD);
    chk("arb ready2", 32'(ready), 32'd1);

    // async assert mid-cycle in RUN
    #5;
    set_rst(1'b0);
    chk("t2 rst async", 32'(rst_n_out), 32'd0);
    chk("t2 ready async", 32'(ready), 32'd0);
    repeat (3) step();
    #3;
    set_rst(1'b1);
    step();
    step();
    e2 = e;
    run_to(e2 + PW - 1);
    chk("t2 pwrup", 32'(rst_n_out), 32'd0);
    run_to(e2 + PW + 2 * SD);
    chk("t2 ready", 32'(ready), 32'd1);

    // request pulse during PWRUP is ignored
    por(e2);
    run_to(e2 + 100);
    soft_req = 2'b01;
    step();
    soft_req = '0;
    chk("t5 no grant", 32'(soft_grant), 32'd0);
    run_to(e2 + PW - 1);
    chk("t5 pre", 32'(rst_n_out), 32'd0);
    step();
    chk("t5 d0", 32'(rst_n_out), 32'b001);
    run_to(e2 + PW + 2 * SD);
    chk("t5 ready", 32'(ready), 32'd1);

    // hard reset in the middle of a soft release
    soft_req = 2'b01;
    step();
    g0 = e;
    soft_req = '0;
    run_to(g0 + 12);
    chk("t6 partial", 32'(rst_n_out), 32'b001);
    #5;
    set_rst(1'b0);
    chk("t6 rst", 32'(rst_n_out), 32'd0);
    repeat (2) step();
    #5;
    set_rst(1'b1);
    step();
    step();
    e2 = e;
    run_to(e2 + PW - 1);
    chk("t6 pre", 32'(rst_n_out), 32'd0);
    step();
    chk("t6 d0", 32'(rst_n_out), 32'b001);
    run_to(e2 + PW + 2 * SD);
    chk("t6 ready", 32'(ready), 32'd1);

    // random requests with occasional async resets
    repeat (8000) begin
      for (int i = 0; i < NR; i++)
        if (!soft_req[i] && $urandom_range(0, 29) == 0)
          soft_req[i] = 1'b1;
      if ($urandom_range(0, 2999) == 0) begin
        #($urandom_range(1, 6));
        set_rst(1'b0);
        repeat ($urandom_range(0, 3)) step();
        #($urandom_range(1, 6));
        set_rst(1'b1);
      end
      step();
      soft_req = soft_req & ~soft_grant;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
